// File: rtl/red_pitaya_dac_shaper_pkg.sv
// Shared constants for the DAC output conditioning stage: envelope FSM encoding,
// unity envelope and output saturation limits.
package red_pitaya_dac_shaper_pkg;

   typedef enum logic [1:0] {
      ST_OFF = 2'd0,
      ST_UP  = 2'd1,
      ST_RUN = 2'd2,
      ST_DN  = 2'd3
   } env_state_t;

   localparam logic        [14:0] ENV_ONE = 15'd16384;
   localparam logic signed [13:0] DAC_MAX = 14'sd8191;
   localparam logic signed [13:0] DAC_MIN = 14'sh2000;

endpackage

// File: rtl/red_pitaya_dac_slew.sv
// Output slew-rate limiter: moves the registered output toward the target by at
// most `limit` LSB per cycle; limit 0 passes the target straight through.
module red_pitaya_dac_slew (
   input  logic        dac_clk_i,
   input  logic        dac_rstn_i,
   input  logic [13:0] target,
   input  logic [13:0] limit,
   output logic [13:0] dac_o
);

   logic signed [14:0] diff;
   logic signed [14:0] lim_pos;
   logic signed [14:0] lim_neg;
   logic signed [14:0] step;
   logic        [13:0] dac_d;

   always_comb begin
      diff    = $signed({target[13], target}) - $signed({dac_o[13], dac_o});
      lim_pos = $signed({1'b0, limit});
      lim_neg = -lim_pos;
      step    = diff;
      if (diff > lim_pos) begin
         step = lim_pos;
      end else if (diff < lim_neg) begin
         step = lim_neg;
      end
      // target is in range, so a clamped step toward it never overflows
      if (limit == '0) begin
         dac_d = target;
      end else begin
         dac_d = 14'($signed({dac_o[13], dac_o}) + step);
      end
   end

   always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
      if (!dac_rstn_i) begin
         dac_o <= '0;
      end else begin
         dac_o <= dac_d;
      end
   end

endmodule

// File: rtl/red_pitaya_dac_shaper.sv
// Per-channel DAC conditioning: calibration gain/offset with saturation,
// soft-start/stop envelope, slew limiting and clip statistics.
//
// state | meaning
// OFF   | output muted, env held at 0, waiting for enable
// UP    | env ramping toward unity by cfg_ramp_i per cycle
// RUN   | env at unity
// DN    | env ramping toward 0 by cfg_ramp_i per cycle
module red_pitaya_dac_shaper
   import red_pitaya_dac_shaper_pkg::*;
(
   input  logic        dac_clk_i,
   input  logic        dac_rstn_i,
   input  logic [13:0] dat_i,
   input  logic [15:0] cfg_gain_i,
   input  logic [13:0] cfg_ofs_i,
   input  logic        cfg_en_i,
   input  logic [14:0] cfg_ramp_i,
   input  logic [13:0] cfg_slew_i,
   input  logic        cfg_clr_i,
   output logic [13:0] dac_o,
   output logic [1:0]  state_o,
   output logic        ramp_done_o,
   output logic [15:0] sat_cnt_o
);

   localparam logic signed [17:0] S2_HI = 18'(DAC_MAX);
   localparam logic signed [17:0] S2_LO = 18'(DAC_MIN);

   env_state_t         state_q, state_d;
   logic        [14:0] env_q, env_d;
   logic               done_q, done_d;
   logic        [16:0] env_up;
   logic signed [16:0] env_dn;

   logic signed [30:0] p1;
   logic signed [16:0] s1_q;
   logic signed [17:0] s2_sum;
   logic signed [13:0] s2_d, s2_q;
   logic               sat2;
   logic signed [29:0] p3;
   logic signed [13:0] s3_q;
   logic        [15:0] sat_cnt_q;

   assign p1     = 31'($signed(dat_i)) * 31'($signed({1'b0, cfg_gain_i}));
   assign s2_sum = 18'(s1_q) + 18'($signed(cfg_ofs_i));
   assign p3     = 30'(s2_q) * 30'($signed({1'b0, env_q}));

   always_comb begin
      s2_d = s2_sum[13:0];
      sat2 = 1'b0;
      if (s2_sum > S2_HI) begin
         s2_d = DAC_MAX;
         sat2 = 1'b1;
      end else if (s2_sum < S2_LO) begin
         s2_d = DAC_MIN;
         sat2 = 1'b1;
      end
   end

   always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
      if (!dac_rstn_i) begin
         s1_q      <= '0;
         s2_q      <= '0;
         s3_q      <= '0;
         sat_cnt_q <= '0;
      end else begin
         s1_q <= 17'(p1 >>> 14);
         s2_q <= s2_d;
         s3_q <= 14'(p3 >>> 14);
         if (cfg_clr_i) begin
            sat_cnt_q <= '0;
         end else if (sat2 && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
         end
      end
   end

   // A reversal of cfg_en_i is tested before ramp completion so it always wins.
   always_comb begin
      state_d = state_q;
      env_d   = env_q;
      done_d  = 1'b0;
      env_up  = {2'b00, env_q} + {2'b00, cfg_ramp_i};
      env_dn  = $signed({2'b00, env_q}) - $signed({2'b00, cfg_ramp_i});
      case (state_q)
         ST_OFF: begin
            env_d = '0;
            if (cfg_en_i) state_d = ST_UP;
         end
         ST_UP: begin
            if (!cfg_en_i) begin
               state_d = ST_DN;
            end else if ((cfg_ramp_i == '0) || (env_up >= 17'(ENV_ONE))) begin
               env_d   = ENV_ONE;
               state_d = ST_RUN;
               done_d  = 1'b1;
            end else begin
               env_d = env_up[14:0];
            end
         end
         ST_RUN: begin
            env_d = ENV_ONE;
            if (!cfg_en_i) state_d = ST_DN;
         end
         ST_DN: begin
            if (cfg_en_i) begin
               state_d = ST_UP;
            end else if ((cfg_ramp_i == '0) || (env_dn <= 17'sd0)) begin
               env_d   = '0;
               state_d = ST_OFF;
               done_d  = 1'b1;
            end else begin
               env_d = env_dn[14:0];
            end
         end
         default: begin
            env_d   = '0;
            state_d = ST_OFF;
         end
      endcase
   end

   always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
      if (!dac_rstn_i) begin
         state_q <= ST_OFF;
         env_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         env_q   <= env_d;
         done_q  <= done_d;
      end
   end

   red_pitaya_dac_slew u_slew (
      .dac_clk_i  (dac_clk_i),
      .dac_rstn_i (dac_rstn_i),
      .target     (s3_q),
      .limit      (cfg_slew_i),
      .dac_o      (dac_o)
   );

   assign state_o     = state_q;
   assign ramp_done_o = done_q;
   assign sat_cnt_o   = sat_cnt_q;

endmodule

// File: tb/tb_red_pitaya_dac_shaper.sv
// Self-checking bench for red_pitaya_dac_shaper: expected samples and FSM
// outputs are queued when stimulus is applied and compared as the DUT produces them.
module tb_red_pitaya_dac_shaper;

   logic        dac_clk_i = 1'b0;
   logic        dac_rstn_i;
   logic [13:0] dat_i;
   logic [15:0] cfg_gain_i;
   logic [13:0] cfg_ofs_i;
   logic        cfg_en_i;
   logic [14:0] cfg_ramp_i;
   logic [13:0] cfg_slew_i;
   logic        cfg_clr_i;
   logic [13:0] dac_o;
   logic [1:0]  state_o;
   logic        ramp_done_o;
   logic [15:0] sat_cnt_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int st;
      int done;
      int dac;
      int en_next;
   } env_exp_t;

   int       q_dac[$];
   env_exp_t q_env[$];

   red_pitaya_dac_shaper dut (
      .dac_clk_i   (dac_clk_i),
      .dac_rstn_i  (dac_rstn_i),
      .dat_i       (dat_i),
      .cfg_gain_i  (cfg_gain_i),
      .cfg_ofs_i   (cfg_ofs_i),
      .cfg_en_i    (cfg_en_i),
      .cfg_ramp_i  (cfg_ramp_i),
      .cfg_slew_i  (cfg_slew_i),
      .cfg_clr_i   (cfg_clr_i),
      .dac_o       (dac_o),
      .state_o     (state_o),
      .ramp_done_o (ramp_done_o),
      .sat_cnt_o   (sat_cnt_o)
   );

   always #5 dac_clk_i = ~dac_clk_i;

   initial begin
      #1000000;
      $display("FAIL watchdog expired got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic int ref_cal(input int d, input int g, input int o);
      longint p;
      longint s;
      p = longint'(d) * longint'(g);
      s = (p >>> 14) + longint'(o);
      if (s > 8191) s = 8191;
      if (s < -8192) s = -8192;
      return int'(s);
   endfunction

   function automatic int ref_clip(input int d, input int g, input int o);
      longint p;
      longint s;
      p = longint'(d) * longint'(g);
      s = (p >>> 14) + longint'(o);
      return ((s > 8191) || (s < -8192)) ? 1 : 0;
   endfunction

   task automatic tick;
      @(posedge dac_clk_i);
      #1;
   endtask

   task automatic test_reset;
      int got;
      dac_rstn_i = 1'b0;
      dat_i      = '0;
      cfg_gain_i = 16'h4000;
      cfg_ofs_i  = '0;
      cfg_en_i   = 1'b0;
      cfg_ramp_i = '0;
      cfg_slew_i = '0;
      cfg_clr_i  = 1'b0;
      #3;
      got = $signed(dac_o);
      checks++; if (got !== 0) begin errors++; $display("FAIL reset_dac got %0d want 0", got); end
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
      checks++; if (ramp_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %0d want 0", ramp_done_o); end
      checks++; if (sat_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_satcnt got %0d want 0", sat_cnt_o); end
      #19;
      dac_rstn_i = 1'b1;
      tick();
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_hold_off got %0d want 0", state_o); end
   endtask

   task automatic test_instant_ramp;
      cfg_ramp_i = '0;
      cfg_en_i   = 1'b1;
      tick();
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL inst_up got %0d want 1", state_o); end
      checks++; if (ramp_done_o !== 1'b0) begin errors++; $display("FAIL inst_up_done got %0d want 0", ramp_done_o); end
      tick();
      checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL inst_run got %0d want 2", state_o); end
      checks++; if (ramp_done_o !== 1'b1) begin errors++; $display("FAIL inst_run_done got %0d want 1", ramp_done_o); end
      tick();
      checks++; if (ramp_done_o !== 1'b0) begin errors++; $display("FAIL inst_done_pulse got %0d want 0", ramp_done_o); end
   endtask

   task automatic test_latency;
      int stim[11] = '{0, 0, 0, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
      int e;
      int got;
      cfg_gain_i = 16'h4000;
      cfg_ofs_i  = '0;
      cfg_slew_i = '0;
      dat_i      = '0;
      repeat (6) tick();
      q_dac.delete();
      foreach (stim[i]) begin
         dat_i = 14'(stim[i]);
         q_dac.push_back(ref_cal(stim[i], 16'h4000, 0));
         tick();
         if (q_dac.size() == 4) begin
            e   = q_dac.pop_front();
            got = $signed(dac_o);
            checks++;
            if (got !== e) begin errors++; $display("FAIL latency_dac[%0d] got %0d want %0d", i, got, e); end
         end
      end
      checks++; if (sat_cnt_o !== 16'd0) begin errors++; $display("FAIL latency_satcnt got %0d want 0", sat_cnt_o); end
   endtask

   task automatic test_saturation;
      int e;
      int got;
      int d;
      int exp_sat = 0;
      cfg_gain_i = 16'h8000;
      cfg_ofs_i  = '0;
      dat_i      = '0;
      repeat (6) tick();
      q_dac.delete();
      for (int i = 0; i < 17; i++) begin
         d = (i >= 2 && i < 12) ? 5000 : 0;
         dat_i = 14'(d);
         q_dac.push_back(ref_cal(d, 16'h8000, 0));
         exp_sat += ref_clip(d, 16'h8000, 0);
         tick();
         if (q_dac.size() == 4) begin
            e   = q_dac.pop_front();
            got = $signed(dac_o);
            checks++;
            if (got !== e) begin errors++; $display("FAIL sat_dac[%0d] got %0d want %0d", i, got, e); end
         end
      end
      checks++; if (int'(sat_cnt_o) !== exp_sat) begin errors++; $display("FAIL sat_count got %0d want %0d", sat_cnt_o, exp_sat); end
      dat_i = 14'd5000;
      tick();
      dat_i     = '0;
      cfg_clr_i = 1'b1;
      tick();
      cfg_clr_i = 1'b0;
      checks++; if (sat_cnt_o !== 16'd0) begin errors++; $display("FAIL sat_clr_wins got %0d want 0", sat_cnt_o); end
      repeat (4) tick();
      checks++; if (sat_cnt_o !== 16'd0) begin errors++; $display("FAIL sat_clr_hold got %0d want 0", sat_cnt_o); end
   endtask

   task automatic test_patterns;
      int gains[5] = '{16'h4000, 16'h2000, 16'hFFFF, 16'h8000, 16'h0000};
      int ofss[5]  = '{100, -500, 0, -8192, 8191};
      logic [13:0] r14;
      int d;
      int e;
      int got;
      int exp_sat;
      for (int c = 0; c < 5; c++) begin
         cfg_gain_i = 16'(gains[c]);
         cfg_ofs_i  = 14'(ofss[c]);
         dat_i      = '0;
         repeat (5) tick();
         cfg_clr_i = 1'b1;
         tick();
         cfg_clr_i = 1'b0;
         tick();
         exp_sat = 0;
         q_dac.delete();
         for (int i = 0; i < 26; i++) begin
            if (i == 0) d = -8192;
            else if (i == 1) d = 8191;
            else if (i < 22) begin
               r14 = 14'($urandom_range(0, 16383));
               d   = $signed(r14);
            end else d = 0;
            dat_i = 14'(d);
            q_dac.push_back(ref_cal(d, gains[c], ofss[c]));
            exp_sat += ref_clip(d, gains[c], ofss[c]);
            tick();
            if (q_dac.size() == 4) begin
               e   = q_dac.pop_front();
               got = $signed(dac_o);
               checks++;
               if (got !== e) begin errors++; $display("FAIL pattern_dac[%0d][%0d] got %0d want %0d", c, i, got, e); end
            end
         end
         checks++;
         if (int'(sat_cnt_o) !== exp_sat) begin errors++; $display("FAIL pattern_satcnt[%0d] got %0d want %0d", c, sat_cnt_o, exp_sat); end
      end
   endtask

   task automatic run_env_queue(input string name);
      env_exp_t x;
      int got;
      int n = 0;
      while (q_env.size() > 0) begin
         tick();
         x   = q_env.pop_front();
         got = $signed(dac_o);
         n++;
         checks++; if (int'(state_o) !== x.st) begin errors++; $display("FAIL %s_state[%0d] got %0d want %0d", name, n, state_o, x.st); end
         checks++; if (int'(ramp_done_o) !== x.done) begin errors++; $display("FAIL %s_done[%0d] got %0d want %0d", name, n, ramp_done_o, x.done); end
         checks++; if (got !== x.dac) begin errors++; $display("FAIL %s_dac[%0d] got %0d want %0d", name, n, got, x.dac); end
         cfg_en_i = x.en_next[0];
      end
   endtask

   task automatic go_off;
      cfg_ramp_i = '0;
      cfg_en_i   = 1'b0;
      repeat (6) tick();
   endtask

   task automatic test_ramp_up;
      go_off();
      cfg_ramp_i = 15'd4096;
      cfg_gain_i = 16'h4000;
      cfg_ofs_i  = '0;
      cfg_slew_i = '0;
      dat_i      = 14'd8000;
      repeat (5) tick();
      checks++; if (dac_o !== 14'd0) begin errors++; $display("FAIL rampup_pre_dac got %0d want 0", dac_o); end
      q_env.delete();
      q_env.push_back('{1, 0, 0, 1});
      q_env.push_back('{1, 0, 0, 1});
      q_env.push_back('{1, 0, 0, 1});
      q_env.push_back('{1, 0, 2000, 1});
      q_env.push_back('{2, 1, 4000, 1});
      q_env.push_back('{2, 0, 6000, 1});
      q_env.push_back('{2, 0, 8000, 1});
      q_env.push_back('{2, 0, 8000, 1});
      cfg_en_i = 1'b1;
      run_env_queue("rampup");
   endtask

   task automatic test_ramp_down;
      cfg_ramp_i = 15'd4096;
      cfg_en_i   = 1'b0;
      repeat (10) tick();
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rampdn_pre_state got %0d want 0", state_o); end
      q_env.delete();
      q_env.push_back('{1, 0, 0, 1});
      q_env.push_back('{1, 0, 0, 1});
      q_env.push_back('{1, 0, 0, 0});
      q_env.push_back('{3, 0, 2000, 0});
      q_env.push_back('{3, 0, 4000, 0});
      q_env.push_back('{0, 1, 4000, 0});
      q_env.push_back('{0, 0, 2000, 0});
      q_env.push_back('{0, 0, 0, 0});
      q_env.push_back('{0, 0, 0, 0});
      cfg_en_i = 1'b1;
      run_env_queue("rampdn");
   endtask

   task automatic test_reverse;
      cfg_ramp_i = 15'd8192;
      q_env.delete();
      q_env.push_back('{1, 0, 0, 1});
      q_env.push_back('{1, 0, 0, 0});
      q_env.push_back('{3, 0, 0, 1});
      q_env.push_back('{1, 0, 4000, 1});
      q_env.push_back('{2, 1, 4000, 1});
      q_env.push_back('{2, 0, 4000, 1});
      q_env.push_back('{2, 0, 8000, 1});
      cfg_en_i = 1'b1;
      run_env_queue("reverse");
   endtask

   task automatic test_slew;
      int e;
      int got;
      cfg_gain_i = 16'h4000;
      cfg_ofs_i  = '0;
      cfg_slew_i = '0;
      dat_i      = '0;
      repeat (6) tick();
      cfg_slew_i = 14'd10;
      repeat (2) tick();
      q_dac.delete();
      for (int k = 1; k <= 106; k++) begin
         e = 10 * (k - 3);
         if (e < 0) e = 0;
         if (e > 1000) e = 1000;
         q_dac.push_back(e);
      end
      dat_i = 14'd1000;
      for (int k = 1; k <= 106; k++) begin
         tick();
         e   = q_dac.pop_front();
         got = $signed(dac_o);
         checks++;
         if (got !== e) begin errors++; $display("FAIL slew_up[%0d] got %0d want %0d", k, got, e); end
      end
      for (int k = 1; k <= 206; k++) begin
         e = 1000 - 10 * (k - 3);
         if (e > 1000) e = 1000;
         if (e < -1000) e = -1000;
         q_dac.push_back(e);
      end
      dat_i = 14'(-1000);
      for (int k = 1; k <= 206; k++) begin
         tick();
         e   = q_dac.pop_front();
         got = $signed(dac_o);
         checks++;
         if (got !== e) begin errors++; $display("FAIL slew_dn[%0d] got %0d want %0d", k, got, e); end
      end
      cfg_slew_i = '0;
   endtask

   task automatic test_async_reset;
      go_off();
      cfg_gain_i = 16'h4000;
      cfg_ofs_i  = '0;
      dat_i      = 14'd8000;
      cfg_ramp_i = 15'd512;
      cfg_en_i   = 1'b1;
      repeat (12) tick();
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL arst_pre_state got %0d want 1", state_o); end
      checks++; if (dac_o === 14'd0) begin errors++; $display("FAIL arst_pre_dac got %0d want nonzero", dac_o); end
      #2;
      dac_rstn_i = 1'b0;
      #1;
      checks++; if (dac_o !== 14'd0) begin errors++; $display("FAIL arst_dac got %0d want 0", dac_o); end
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL arst_state got %0d want 0", state_o); end
      checks++; if (ramp_done_o !== 1'b0) begin errors++; $display("FAIL arst_done got %0d want 0", ramp_done_o); end
      cfg_en_i = 1'b0;
      #2;
      dac_rstn_i = 1'b1;
      #1;
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL arst_release_state got %0d want 0", state_o); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL arst_off_hold[%0d] got %0d want 0", k, state_o); end
         checks++; if (dac_o !== 14'd0) begin errors++; $display("FAIL arst_off_dac[%0d] got %0d want 0", k, dac_o); end
      end
      cfg_en_i = 1'b1;
      tick();
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL arst_en_up got %0d want 1", state_o); end
   endtask

   initial begin
      test_reset();
      test_instant_ramp();
      test_latency();
      test_saturation();
      test_patterns();
      test_ramp_up();
      test_ramp_down();
      test_reverse();
      test_slew();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/red_pitaya_dac_shaper.md
# red_pitaya_dac_shaper

Per-channel DAC output conditioning stage, instantiated once per channel directly downstream of each ASG channel's `dac_o` and upstream of the DAC interface's offset-binary conversion.
- Applies calibration gain and offset with saturation.
- Applies a soft-start/soft-stop amplitude envelope driven by an enable FSM.
- Applies an optional per-sample slew-rate limit.
- Reports state and saturation statistics to the register bank.

## Interface
Parameters:
- `ENV_ONE`, 16384: envelope value representing gain 1.0 (Q1.14); fixed, not overridable per instance.

Ports (one clock domain; reset is asynchronous and active-low):
- `dac_clk_i`  in  1  DAC clock.
- `dac_rstn_i`  in  1  asynchronous active-low reset.
- `dat_i`  in  14  signed sample from ASG channel, valid every cycle.
- `cfg_gain_i`  in  16  unsigned calibration gain, Q2.14 (0x4000 = 1.0).
- `cfg_ofs_i`  in  14  signed calibration offset, LSB units.
- `cfg_en_i`  in  1  output enable level; rise starts ramp-up, fall starts ramp-down.
- `cfg_ramp_i`  in  15  envelope step per cycle; 0 = instantaneous.
- `cfg_slew_i`  in  14  unsigned max output change per cycle; 0 = unlimited.
- `cfg_clr_i`  in  1  synchronous clear of `sat_cnt_o`.
- `dac_o`  out  14  signed conditioned sample (two's complement).
- `state_o`  out  2  FSM state: OFF=0, UP=1, RUN=2, DN=3.
- `ramp_done_o`  out  1  one-cycle pulse on entry to RUN or OFF from a ramp state.
- `sat_cnt_o`  out  16  saturating count of cycles in which stage 2 clipped.

## Operation
- Reset: all pipeline registers 0, env 0, state OFF, `dac_o` 0, `ramp_done_o` 0, `sat_cnt_o` 0. A reset mid-ramp returns immediately to OFF.
- Stage 1: `p1 = dat_i * {1'b0,cfg_gain_i}` (signed, 31 bits); `s1 = p1 >>> 14` (arithmetic, truncating toward -inf).
- Stage 2: `s2 = s1 + cfg_ofs_i`; saturate to [-8192, 8191]. Set the internal sat flag when clipped.
- Stage 3: `s3 = (s2 * env) >>> 14` with env ∈ [0, 16384]. The result always fits in 14 bits; -8192·1.0 = -8192.
- Stage 4, slew limiter:
  - `cfg_slew_i` = 0 → `dac_o <= s3`.
  - otherwise `d = s3 - dac_o` (15-bit signed), clamped to ±`cfg_slew_i`, and `dac_o <= dac_o + d_clamped`.
  - Sum cannot leave range because the target is in range.
- Envelope FSM, evaluated every cycle:
  - OFF: env = 0. `cfg_en_i` = 1 → UP.
  - UP: env += `cfg_ramp_i`. If the result ≥ ENV_ONE, or `cfg_ramp_i` = 0: env = ENV_ONE → RUN, and pulse `ramp_done_o`. `cfg_en_i` = 0 → DN with env unchanged that cycle.
  - RUN: env = ENV_ONE. `cfg_en_i` = 0 → DN.
  - DN: env -= `cfg_ramp_i`. If the result ≤ 0, or `cfg_ramp_i` = 0: env = 0 → OFF, and pulse `ramp_done_o`. `cfg_en_i` = 1 → UP with env unchanged that cycle.
- Enable priority: reversing `cfg_en_i` in the same cycle a ramp would complete takes priority over completion. No `ramp_done_o` pulse is generated in that case.
- `sat_cnt_o`: +1 per clipped cycle, holding at 0xFFFF. If `cfg_clr_i` and a clip occur in the same cycle, clear wins, and the result is 0.
- `state_o` reflects the FSM register directly.

## Timing
- Latency `dat_i` → `dac_o` is 4 cycles, measured with env = ENV_ONE and slew = 0.
- env register update → effect on `dac_o` is 2 cycles (stage 3, then stage 4).
- `cfg_en_i` rise → `state_o` = UP on the next edge. env reaches the first nonzero value one cycle later.
- Config inputs are quasi-static and sampled every cycle. No shadowing is required.
- `ramp_done_o` is registered and asserts in the same cycle `state_o` shows RUN or OFF.

## Structure
- Package `red_pitaya_dac_shaper_pkg` holds:
  - state encoding constants (OFF/UP/RUN/DN);
  - ENV_ONE = 16384;
  - saturation limits DAC_MAX = 8191 and DAC_MIN = -8192.
- Sub-module `red_pitaya_dac_slew` holds stage 4 only: registered output, async reset, ports `dac_clk_i`, `dac_rstn_i`, target, limit, output.
- Stages 1–3, the FSM and the counter stay in the top module.

## Test plan
- Gain 0x4000, ofs 0, env held at RUN, slew 0, `dat_i` step 0→1000 → `dac_o` = 1000 exactly 4 cycles after the step; `sat_cnt_o` stays 0.
- Gain 0x8000, `dat_i` = 5000 for 10 cycles → `dac_o` = 8191 and `sat_cnt_o` = 10. Then `cfg_clr_i` is asserted for one cycle together with a clipping sample → `sat_cnt_o` = 0.
- `cfg_ramp_i` = 4096, `cfg_en_i` 0→1, `dat_i` = 8000 → env sequence 4096, 8192, 12288, 16384. RUN is entered 4 cycles after UP with a single `ramp_done_o` pulse. `dac_o` follows 2000, 4000, 6000, 8000.
- In UP with env = 8192, drop `cfg_en_i` → DN on the next edge, env 8192 then 4096, then 0 → OFF with `ramp_done_o` pulse; `dac_o` settles to 0.
- Slew 10, RUN, `dat_i` 0→1000 → `dac_o` rises by exactly 10 per cycle, reaching 1000 in 100 cycles. Step to -1000 → falls by 10 per cycle.
- Assert `dac_rstn_i` low asynchronously mid-UP → `dac_o`, `state_o` and env are 0 immediately, without waiting for a clock edge. After release, OFF holds until `cfg_en_i` is seen high.
